// File: rtl/alu_result_display_if.sv
// Result handshake between the ALU operation outputs and the display converter.
// A result transfers on a rising edge where res_valid and res_ready are both high; the producer holds res_data stable until then.
interface alu_result_display_if;
   logic       res_valid;
   logic [5:0] res_data;
   logic       res_ready;

   modport master (output res_valid, output res_data, input res_ready);
   modport slave  (input res_valid, input res_data, output res_ready);
endinterface

// File: rtl/alu_result_display.sv
// Converts a 6-bit unsigned ALU result to two BCD digits by double-dabble
// and drives the active-low HEX1 (tens) / HEX0 (units) seven-segment digits.
module alu_result_display #(
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst,
   alu_result_display_if.slave         res,
   output logic                        busy,
   output logic [6:0]                  hex0,
   output logic [6:0]                  hex1,
   output logic [1:0]                  state_dbg
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] LOAD  = 2'd2;

   localparam logic [6:0] SEG_ZERO  = 7'b1000000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   logic [1:0] state;
   logic [5:0] sreg;
   logic [7:0] bcd;
   logic [2:0] step;
   logic [7:0] bcd_adj;

   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   // Nibble values 10-15 cannot occur; they fall through to blank.
   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return SEG_BLANK;
      endcase
   endfunction

   assign bcd_adj = {add3(bcd[7:4]), add3(bcd[3:0])};

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sreg  <= '0;
         bcd   <= '0;
         step  <= '0;
         hex0  <= SEG_ZERO;
         hex1  <= BLANK_LZ ? SEG_BLANK : SEG_ZERO;
      end else begin
         case (state)
            IDLE: begin
               if (res.res_valid) begin
                  sreg  <= res.res_data;
                  bcd   <= '0;
                  step  <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               // Tens never exceeds 6, so the bit shifted out of bcd_adj[7] is always 0.
               bcd  <= {bcd_adj[6:0], sreg[5]};
               sreg <= {sreg[4:0], 1'b0};
               step <= step + 3'd1;
               if (step == 3'd5)
                  state <= LOAD;
            end
            LOAD: begin
               hex0 <= seg7(bcd[3:0]);
               hex1 <= (BLANK_LZ && bcd[7:4] == 4'd0) ? SEG_BLANK : seg7(bcd[7:4]);
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign res.res_ready = (state == IDLE);
   assign busy          = (state == SHIFT) || (state == LOAD);
   assign state_dbg     = state;

endmodule

// File: tb/tb_alu_result_display.sv
// Directed bench for alu_result_display: reset values, conversions, latency,
// back-pressure while busy, mid-conversion reset and the unblanked tens variant.
module tb_alu_result_display;

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
   localparam logic [6:0] S6 = 7'b0000010, S7 = 7'b1111000, S9 = 7'b0010000;
   localparam logic [6:0] SB = 7'b1111111;

   logic       clk;
   logic       rst;
   logic       busy, busy_nb;
   logic [6:0] hex0, hex1, hex0_nb, hex1_nb;
   logic [1:0] state_dbg, state_dbg_nb;

   int passed;
   int total;

   alu_result_display_if res_a ();
   alu_result_display_if res_b ();

   alu_result_display #(.BLANK_LZ(1'b1)) dut (
      .clk(clk), .rst(rst), .res(res_a.slave),
      .busy(busy), .hex0(hex0), .hex1(hex1), .state_dbg(state_dbg)
   );

   alu_result_display #(.BLANK_LZ(1'b0)) dut_nb (
      .clk(clk), .rst(rst), .res(res_b.slave),
      .busy(busy_nb), .hex0(hex0_nb), .hex1(hex1_nb), .state_dbg(state_dbg_nb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   // Raises valid with v at a negedge and returns at the negedge after the
   // accepting edge; valid is left high for the caller to drop or keep.
   task automatic accept(input bit sel_nb, input logic [5:0] v);
      bit done;
      done = 1'b0;
      if (sel_nb) begin res_b.res_valid = 1'b1; res_b.res_data = v; end
      else        begin res_a.res_valid = 1'b1; res_a.res_data = v; end
      for (int i = 0; i < 20 && !done; i++) begin
         if (sel_nb ? res_b.res_ready : res_a.res_ready) done = 1'b1;
         @(posedge clk);
         @(negedge clk);
      end
      if (!done) begin
         total++;
         $error("FAIL accept_timeout: observed no ready expected ready within 20 cycles");
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      passed = 0;
      total  = 0;
      rst = 1'b1;
      res_a.res_valid = 1'b0; res_a.res_data = '0;
      res_b.res_valid = 1'b0; res_b.res_data = '0;

      // Reset for two cycles
      wait_cycles(2);
      rst = 1'b0;
      chk("rst_hex0", hex0, S0);
      chk("rst_hex1", hex1, SB);
      chk("rst_ready", {6'd0, res_a.res_ready}, 7'd1);
      chk("rst_busy", {6'd0, busy}, 7'd0);
      chk("rst_nb_hex1", hex1_nb, S0);
      chk("rst_nb_hex0", hex0_nb, S0);

      // 7: single digit, tens blanked
      accept(1'b0, 6'd7);
      res_a.res_valid = 1'b0;
      chk("r7_busy_e1", {6'd0, busy}, 7'd1);
      chk("r7_ready_e1", {6'd0, res_a.res_ready}, 7'd0);
      wait_cycles(7);
      chk("r7_hex0", hex0, S7);
      chk("r7_hex1", hex1, SB);
      chk("r7_busy_done", {6'd0, busy}, 7'd0);

      // 63: exact latency, digits held through E+6
      accept(1'b0, 6'd63);
      res_a.res_valid = 1'b0;
      wait_cycles(6);
      chk("r63_hold_hex0", hex0, S7);
      chk("r63_hold_hex1", hex1, SB);
      chk("r63_busy_e6", {6'd0, busy}, 7'd1);
      wait_cycles(1);
      chk("r63_hex1", hex1, S6);
      chk("r63_hex0", hex0, S3);
      chk("r63_ready", {6'd0, res_a.res_ready}, 7'd1);

      // 10: tens carry
      accept(1'b0, 6'd10);
      res_a.res_valid = 1'b0;
      wait_cycles(7);
      chk("r10_hex1", hex1, S1);
      chk("r10_hex0", hex0, S0);

      // 49 then 5 held during the conversion
      accept(1'b0, 6'd49);
      res_a.res_data = 6'd5;
      wait_cycles(6);
      chk("bp_ready_e6", {6'd0, res_a.res_ready}, 7'd0);
      wait_cycles(1);
      chk("bp_ready_e7", {6'd0, res_a.res_ready}, 7'd1);
      chk("r49_hex1", hex1, S4);
      chk("r49_hex0", hex0, S9);
      wait_cycles(1);
      chk("bp_busy_e8", {6'd0, busy}, 7'd1);
      res_a.res_valid = 1'b0;
      wait_cycles(7);
      chk("r5_hex1", hex1, SB);
      chk("r5_hex0", hex0, S5);

      // 21 shown, then 33 aborted by reset at E+3
      accept(1'b0, 6'd21);
      res_a.res_valid = 1'b0;
      wait_cycles(7);
      chk("r21_hex1", hex1, S2);
      chk("r21_hex0", hex0, S1);
      accept(1'b0, 6'd33);
      res_a.res_valid = 1'b0;
      wait_cycles(2);
      rst = 1'b1;
      wait_cycles(1);
      rst = 1'b0;
      chk("mid_rst_ready", {6'd0, res_a.res_ready}, 7'd1);
      chk("mid_rst_busy", {6'd0, busy}, 7'd0);
      chk("mid_rst_hex0", hex0, S0);
      chk("mid_rst_hex1", hex1, SB);
      wait_cycles(8);
      chk("mid_rst_stay_hex0", hex0, S0);
      chk("mid_rst_stay_hex1", hex1, SB);

      // Unblanked tens variant
      accept(1'b1, 6'd5);
      res_b.res_valid = 1'b0;
      wait_cycles(7);
      chk("nb_r5_hex1", hex1_nb, S0);
      chk("nb_r5_hex0", hex0_nb, S5);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
